// File: rtl/johnson_counter.sv
// Parameterised Johnson (twisted-ring) counter with binary phase, one-hot decode,
// terminal strobe and illegal-code detection; illegal codes self-correct to zero.
module johnson_counter #(
    parameter int WIDTH = 4,
    localparam int PW = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [WIDTH-1:0]     count,
    output logic [PW-1:0]        phase,
    output logic [2*WIDTH-1:0]   decode,
    output logic                 terminal,
    output logic                 illegal
);

    localparam int PERIOD = 2 * WIDTH;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] inv_count;
    logic             low_ones_form;
    logic             high_ones_form;
    int               ones;
    int               phase_full;

    // x & (x+1) == 0 exactly when x is a run of ones anchored at the LSB (or zero);
    // the complement test covers the run-of-ones-at-MSB half of the sequence.
    always_comb begin
        inv_count      = ~count_q;
        low_ones_form  = ((count_q & (count_q + WIDTH'(1))) == '0);
        high_ones_form = ((inv_count & (inv_count + WIDTH'(1))) == '0);
        illegal        = !(low_ones_form || high_ones_form);
    end

    always_comb begin
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (count_q[i]) begin
                ones = ones + 1;
            end
        end
    end

    always_comb begin
        phase_full = 0;
        decode     = '0;
        if (!illegal) begin
            if (!count_q[WIDTH-1] || (count_q == '1)) begin
                phase_full = ones;
            end else begin
                phase_full = PERIOD - ones;
            end
        end
        phase = PW'(phase_full);
        if (!illegal) begin
            decode[phase] = 1'b1;
        end
        terminal = (count_q == {1'b1, {(WIDTH-1){1'b0}}});
    end

    always_comb begin
        count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        if (illegal) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench: four counters (WIDTH 4, 2, 5, 8) run in lockstep against a
// phase-tracking reference whose expectations are queued per edge and popped on check.
module tb_johnson_counter;

    localparam int NINST = 4;

    typedef struct {
        int          inst;
        logic [15:0] count;
        logic [4:0]  phase;
        logic [31:0] decode;
        logic        terminal;
        logic        illegal;
    } exp_t;

    logic clk;
    logic reset;

    logic [3:0]  count4;
    logic [2:0]  phase4;
    logic [7:0]  decode4;
    logic        terminal4;
    logic        illegal4;
    logic [1:0]  count2;
    logic [1:0]  phase2;
    logic [3:0]  decode2;
    logic        terminal2;
    logic        illegal2;
    logic [4:0]  count5;
    logic [3:0]  phase5;
    logic [9:0]  decode5;
    logic        terminal5;
    logic        illegal5;
    logic [7:0]  count8;
    logic [3:0]  phase8;
    logic [15:0] decode8;
    logic        terminal8;
    logic        illegal8;

    logic [15:0] obs_count [NINST];
    logic [4:0]  obs_phase [NINST];
    logic [31:0] obs_decode [NINST];
    logic        obs_terminal [NINST];
    logic        obs_illegal [NINST];

    exp_t sb[$];
    int   ph [NINST];
    int   cmp_count;
    int   fail_count;

    johnson_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .count(count4), .phase(phase4),
        .decode(decode4), .terminal(terminal4), .illegal(illegal4));
    johnson_counter #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .count(count2), .phase(phase2),
        .decode(decode2), .terminal(terminal2), .illegal(illegal2));
    johnson_counter #(.WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .count(count5), .phase(phase5),
        .decode(decode5), .terminal(terminal5), .illegal(illegal5));
    johnson_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .count(count8), .phase(phase8),
        .decode(decode8), .terminal(terminal8), .illegal(illegal8));

    assign obs_count[0] = {12'b0, count4};
    assign obs_count[1] = {14'b0, count2};
    assign obs_count[2] = {11'b0, count5};
    assign obs_count[3] = {8'b0, count8};
    assign obs_phase[0] = {2'b0, phase4};
    assign obs_phase[1] = {3'b0, phase2};
    assign obs_phase[2] = {1'b0, phase5};
    assign obs_phase[3] = {1'b0, phase8};
    assign obs_decode[0] = {24'b0, decode4};
    assign obs_decode[1] = {28'b0, decode2};
    assign obs_decode[2] = {22'b0, decode5};
    assign obs_decode[3] = {16'b0, decode8};
    assign obs_terminal[0] = terminal4;
    assign obs_terminal[1] = terminal2;
    assign obs_terminal[2] = terminal5;
    assign obs_terminal[3] = terminal8;
    assign obs_illegal[0] = illegal4;
    assign obs_illegal[1] = illegal2;
    assign obs_illegal[2] = illegal5;
    assign obs_illegal[3] = illegal8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int inst);
        case (inst)
            0:       return 4;
            1:       return 2;
            2:       return 5;
            default: return 8;
        endcase
    endfunction

    // Reference: phase p of a W-bit ring is p low ones for p <= W, otherwise
    // 2W-p ones packed against the MSB.
    function automatic exp_t model(input int inst, input int p);
        exp_t        e;
        int          w;
        logic [31:0] all_ones;
        logic [31:0] c;
        w        = width_of(inst);
        all_ones = (32'd1 << w) - 32'd1;
        if (p <= w) begin
            c = (32'd1 << p) - 32'd1;
        end else begin
            c = (all_ones << (p - w)) & all_ones;
        end
        e.inst     = inst;
        e.count    = c[15:0];
        e.phase    = 5'(p);
        e.decode   = 32'd1 << p;
        e.terminal = (p == 2 * w - 1);
        e.illegal  = 1'b0;
        return e;
    endfunction

    task automatic checkField(input string tag, input int inst,
                              input logic [31:0] observed, input logic [31:0] expected);
        cmp_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s (W=%0d): observed %0h expected %0h",
                   tag, width_of(inst), observed, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkField("count",    e.inst, 32'(obs_count[e.inst]),    32'(e.count));
            checkField("phase",    e.inst, 32'(obs_phase[e.inst]),    32'(e.phase));
            checkField("decode",   e.inst, obs_decode[e.inst],        e.decode);
            checkField("terminal", e.inst, 32'(obs_terminal[e.inst]), 32'(e.terminal));
            checkField("illegal",  e.inst, 32'(obs_illegal[e.inst]),  32'(e.illegal));
        end
    endtask

    task automatic applyStimulus(input logic rst);
        reset = rst;
        for (int i = 0; i < NINST; i++) begin
            ph[i] = rst ? 0 : (ph[i] + 1) % (2 * width_of(i));
            sb.push_back(model(i, ph[i]));
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        exp_t bad;
        cmp_count  = 0;
        fail_count = 0;
        reset      = 1'b1;
        for (int i = 0; i < NINST; i++) begin
            ph[i] = 0;
        end
        @(negedge clk);

        applyStimulus(1'b1);
        applyStimulus(1'b1);

        // Full cycle plus wrap; WIDTH=4 reaches 1000 (terminal) and then 0000.
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b0);
        end

        // WIDTH=4 now at phase 0; walk to 0111 and reset mid-run.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0);
        end
        applyStimulus(1'b1);
        applyStimulus(1'b0);

        // Plant an illegal code in the WIDTH=4 ring and watch it recover.
        force dut4.count_q = 4'b0101;
        #1;
        release dut4.count_q;
        #1;
        bad.inst     = 0;
        bad.count    = 16'h0005;
        bad.phase    = 5'd0;
        bad.decode   = 32'd0;
        bad.terminal = 1'b0;
        bad.illegal  = 1'b1;
        sb.push_back(bad);
        checkOutput();
        ph[0] = 7;
        applyStimulus(1'b0);
        applyStimulus(1'b0);

        // Long sweep so the WIDTH=8 ring (period 16) wraps as well.
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
